// File: rtl/sys_mem_arb_if.sv
// Controller-side command/return bundle for sys_mem_arb.
// master = arbiter side, slave = memory controller side.
interface sys_mem_arb_if #(
  parameter int MEM_DATA_W = 32,
  parameter int MEM_ADDR_W = 27
);
  logic                  cntrlr_rdy;
  logic                  cntrlr_wren;
  logic                  cntrlr_rden;
  logic [MEM_ADDR_W-1:0] cntrlr_addr;
  logic [MEM_DATA_W-1:0] cntrlr_wdata;
  logic                  cntrlr_rd_valid;
  logic [MEM_DATA_W-1:0] cntrlr_rdata;

  modport master (
    input  cntrlr_rdy,
    input  cntrlr_rd_valid,
    input  cntrlr_rdata,
    output cntrlr_wren,
    output cntrlr_rden,
    output cntrlr_addr,
    output cntrlr_wdata
  );

  modport slave (
    output cntrlr_rdy,
    output cntrlr_rd_valid,
    output cntrlr_rdata,
    input  cntrlr_wren,
    input  cntrlr_rden,
    input  cntrlr_addr,
    input  cntrlr_wdata
  );
endinterface

// File: rtl/sys_mem_arb.sv
// N-agent arbiter onto one memory controller port; an in-order
// tag FIFO routes read returns back to the issuing agent.
module sys_mem_arb #(
  parameter int NUM_AGENTS         = 2,
  parameter int MEM_DATA_W         = 32,
  parameter int MEM_ADDR_W         = 27,
  parameter int ARB_MODE           = 0,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_AGENTS-1:0]            agent_wren,
  input  logic [NUM_AGENTS-1:0]            agent_rden,
  input  logic [NUM_AGENTS*MEM_ADDR_W-1:0] agent_addr,
  input  logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_wdata,
  output logic [NUM_AGENTS-1:0]            agent_wait,
  output logic [NUM_AGENTS-1:0]            agent_rd_valid,
  output logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_rdata,
  sys_mem_arb_if.master                    cntrlr,
  output logic [$clog2(MAX_RD_OUTSTANDING):0] rd_outstanding,
  output logic                             err_unexp_rd
);

  localparam int IDX_W = $clog2(NUM_AGENTS);
  localparam int PTR_W = $clog2(MAX_RD_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  go;
  logic                  gnt_wr;
  logic                  push;
  logic                  pop;
  int                    cand;
  logic [NUM_AGENTS-1:0] elig;

  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic [MEM_ADDR_W-1:0] gnt_addr;
  logic [MEM_DATA_W-1:0] gnt_wdata;

  logic [IDX_W-1:0]      tag_mem [MAX_RD_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [NUM_AGENTS-1:0] rd_valid_q;
  logic [MEM_DATA_W-1:0] rdata_q;

  assign fifo_full  = (count == CNT_W'(MAX_RD_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // Full is judged on registered occupancy, so a same-cycle pop
  // never opens a slot for a same-cycle read grant.
  always_comb begin
    for (int i = 0; i < NUM_AGENTS; i++) begin
      elig[i] = agent_wren[i] | (agent_rden[i] & ~fifo_full);
    end
  end

  // Walk the search order backwards so the first hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int s = NUM_AGENTS - 1; s >= 0; s--) begin
      if (ARB_MODE == 1) begin
        cand = s;
      end else begin
        cand = (int'(rr_ptr) + 1 + s) % NUM_AGENTS;
      end
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  assign go        = gnt_vld & cntrlr.cntrlr_rdy & rst_n;
  assign gnt_wr    = agent_wren[gnt_idx];
  assign push      = go & ~gnt_wr;
  assign pop       = cntrlr.cntrlr_rd_valid & ~fifo_empty;
  assign gnt_addr  =
    agent_addr[int'(gnt_idx)*MEM_ADDR_W +: MEM_ADDR_W];
  assign gnt_wdata =
    agent_wdata[int'(gnt_idx)*MEM_DATA_W +: MEM_DATA_W];

  always_comb begin
    agent_wait          = '1;
    cntrlr.cntrlr_wren  = 1'b0;
    cntrlr.cntrlr_rden  = 1'b0;
    cntrlr.cntrlr_addr  = addr_q;
    cntrlr.cntrlr_wdata = wdata_q;
    if (go) begin
      agent_wait[gnt_idx] = 1'b0;
      cntrlr.cntrlr_wren  = gnt_wr;
      cntrlr.cntrlr_rden  = ~gnt_wr;
      cntrlr.cntrlr_addr  = gnt_addr;
      cntrlr.cntrlr_wdata = gnt_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= IDX_W'(NUM_AGENTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (go) begin
      rr_ptr  <= gnt_idx;
      addr_q  <= gnt_addr;
      wdata_q <= gnt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q   <= '0;
      rdata_q      <= '0;
      err_unexp_rd <= 1'b0;
    end else begin
      rd_valid_q <= pop ?
        (NUM_AGENTS'(1) << tag_mem[rd_ptr]) : '0;
      if (pop) begin
        rdata_q <= cntrlr.cntrlr_rdata;
      end
      if (cntrlr.cntrlr_rd_valid & fifo_empty) begin
        err_unexp_rd <= 1'b1;
      end
    end
  end

  assign agent_rd_valid = rd_valid_q;
  assign agent_rdata    = {NUM_AGENTS{rdata_q}};
  assign rd_outstanding = count;

endmodule

// File: tb/tb_sys_mem_arb.sv
// Self-checking bench for sys_mem_arb: vector table, RR/FP,
// backpressure, read routing scoreboard, FIFO full, error/reset.
module tb_sys_mem_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rdy = 1'b0;
  logic         ret_v = 1'b0;
  logic [31:0]  ret_d = '0;
  logic [3:0]   wren = '0;
  logic [3:0]   rden = '0;
  logic [107:0] addr = '0;
  logic [127:0] wdata = '0;

  logic [3:0]   wt, rv, wt_fp, rv_fp;
  logic [127:0] rdat, rdat_fp;
  logic [3:0]   ro, ro_fp;
  logic         err, err_fp;

  int n_cmp = 0;
  int n_err = 0;
  logic sb_on = 1'b0;
  logic auto_ret = 1'b0;

  always #5 clk = ~clk;

  sys_mem_arb_if #(.MEM_DATA_W(32), .MEM_ADDR_W(27)) if_rr ();
  sys_mem_arb_if #(.MEM_DATA_W(32), .MEM_ADDR_W(27)) if_fp ();

  assign if_rr.cntrlr_rdy      = rdy;
  assign if_rr.cntrlr_rd_valid = ret_v;
  assign if_rr.cntrlr_rdata    = ret_d;
  assign if_fp.cntrlr_rdy      = rdy;
  assign if_fp.cntrlr_rd_valid = 1'b0;
  assign if_fp.cntrlr_rdata    = '0;

  sys_mem_arb #(
    .NUM_AGENTS(4), .MEM_DATA_W(32), .MEM_ADDR_W(27),
    .ARB_MODE(0), .MAX_RD_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .agent_wren(wren), .agent_rden(rden),
    .agent_addr(addr), .agent_wdata(wdata),
    .agent_wait(wt), .agent_rd_valid(rv),
    .agent_rdata(rdat), .cntrlr(if_rr.master),
    .rd_outstanding(ro), .err_unexp_rd(err)
  );

  sys_mem_arb #(
    .NUM_AGENTS(4), .MEM_DATA_W(32), .MEM_ADDR_W(27),
    .ARB_MODE(1), .MAX_RD_OUTSTANDING(8)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .agent_wren(wren), .agent_rden(rden),
    .agent_addr(addr), .agent_wdata(wdata),
    .agent_wait(wt_fp), .agent_rd_valid(rv_fp),
    .agent_rdata(rdat_fp), .cntrlr(if_fp.master),
    .rd_outstanding(ro_fp), .err_unexp_rd(err_fp)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ret_data(input logic [26:0] a);
    logic [15:0] hi;
    case (a[9:8])
      2'd1:    hi = 16'hAAAA;
      2'd2:    hi = 16'hBBBB;
      default: hi = 16'hC0DE;
    endcase
    return {hi, 8'h00, a[7:0]};
  endfunction

  // Controller model: records issued reads, returns them in order.
  typedef struct { logic [26:0] a; int due; } pend_t;
  pend_t pend[$];
  int cyc = 0;

  always @(posedge clk) begin
    if (if_rr.cntrlr_rden) pend.push_back('{if_rr.cntrlr_addr, cyc + 3});
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (auto_ret) begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ret_v = 1'b1;
        ret_d = ret_data(pend[0].a);
        void'(pend.pop_front());
      end else begin
        ret_v = 1'b0;
      end
    end
  end

  // Scoreboard of expected read returns, pushed when a read is driven.
  typedef struct { logic [3:0] oh; logic [31:0] d; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic ret_d1 = 1'b0;

  always @(posedge clk) ret_d1 <= ret_v;

  always @(negedge clk) begin
    if (sb_on && (ret_d1 || rv != 4'h0)) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {60'h0, rv}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_valid", {60'h0, rv}, {60'h0, e.oh});
        chk("rd_data0", {32'h0, rdat[31:0]}, {32'h0, e.d});
        chk("rd_data3", {32'h0, rdat[127:96]}, {32'h0, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int a, input logic [26:0] ad);
    addr[a*27 +: 27] = ad;
  endtask

  task automatic do_read(input int a, input logic [26:0] ad);
    int n;
    logic [3:0] oh;
    n = 0;
    oh = 4'b0001 << a;
    rden[a] = 1'b1;
    set_addr(a, ad);
    exp_q.push_back('{oh, ret_data(ad)});
    @(negedge clk);
    while (wt[a] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_accept_timeout", {32'h0, n < 50}, 64'h1);
    @(posedge clk);
    #1;
    rden[a] = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  wren;
    logic [3:0]  rden;
    logic        rdy;
    logic [3:0]  wt_e;
    logic        wren_e;
    logic        rden_e;
    logic [26:0] addr_e;
    logic [31:0] wdata_e;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int   g;
    int   ex;
    int   k;
    int   pulses;
    int   cnt[4];

    vt[0] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 27'h40, 32'hD000_0000};
    vt[1] = '{4'hF, 4'h0, 1'b1, 4'hD, 1'b1, 1'b0, 27'h41, 32'hD000_0001};
    vt[2] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 27'h41, 32'hD000_0001};
    vt[3] = '{4'h9, 4'h0, 1'b1, 4'h7, 1'b1, 1'b0, 27'h43, 32'hD000_0003};
    vt[4] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 27'h43, 32'hD000_0003};
    vt[5] = '{4'h5, 4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 27'h40, 32'hD000_0000};
    vt[6] = '{4'h5, 4'h0, 1'b1, 4'hB, 1'b1, 1'b0, 27'h42, 32'hD000_0002};
    vt[7] = '{4'h2, 4'h2, 1'b1, 4'hD, 1'b1, 1'b0, 27'h41, 32'hD000_0001};
    vt[8] = '{4'h1, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 27'h41, 32'hD000_0001};
    vt[9] = '{4'h1, 4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 27'h40, 32'hD000_0000};

    for (int i = 0; i < 4; i++) begin
      addr[i*27 +: 27]  = 27'h40 + 27'(i);
      wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    end

    // Reset state, with requests pending and controller ready
    rdy  = 1'b1;
    wren = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_wait", {60'h0, wt}, 64'hF);
    chk("rst_wait_fp", {60'h0, wt_fp}, 64'hF);
    chk("rst_wren", {63'h0, if_rr.cntrlr_wren}, 64'h0);
    chk("rst_rden", {63'h0, if_rr.cntrlr_rden}, 64'h0);
    chk("rst_rv", {60'h0, rv}, 64'h0);
    chk("rst_rdata", rdat[63:0], 64'h0);
    chk("rst_ro", {60'h0, ro}, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    wren = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      wren = vt[i].wren;
      rden = vt[i].rden;
      rdy  = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_wait", i), {60'h0, wt}, {60'h0, vt[i].wt_e});
      chk($sformatf("vec%0d_wren", i), {63'h0, if_rr.cntrlr_wren},
          {63'h0, vt[i].wren_e});
      chk($sformatf("vec%0d_rden", i), {63'h0, if_rr.cntrlr_rden},
          {63'h0, vt[i].rden_e});
      chk($sformatf("vec%0d_addr", i), {37'h0, if_rr.cntrlr_addr},
          {37'h0, vt[i].addr_e});
      chk($sformatf("vec%0d_wdata", i), {32'h0, if_rr.cntrlr_wdata},
          {32'h0, vt[i].wdata_e});
      tick();
    end
    rden = 4'h0;

    // Round-robin fairness over 100 commands
    wren = 4'hF;
    rdy  = 1'b1;
    ex   = 1;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      g = -1;
      for (int j = 0; j < 4; j++) if (!wt[j]) g = j;
      chk("rr_order", 64'(g), 64'(ex));
      if (g >= 0) cnt[g]++;
      ex = (ex + 1) % 4;
      tick();
    end
    for (int j = 0; j < 4; j++) chk($sformatf("rr_share%0d", j),
                                    64'(cnt[j]), 64'd25);

    // Fixed priority: agent 1 beats 3 until it drops
    wren = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fp_hold", {60'h0, wt_fp}, 64'hD);
      tick();
    end
    wren = 4'b1000;
    @(negedge clk);
    chk("fp_next", {60'h0, wt_fp}, 64'h7);
    tick();
    wren = 4'h0;

    // Backpressure with agent 2 reading 0x10..0x13
    sb_on    = 1'b1;
    auto_ret = 1'b1;
    k        = 0;
    pulses   = 0;
    rden[2]  = 1'b1;
    set_addr(2, 27'h10);
    exp_q.push_back('{4'b0100, ret_data(27'h10)});
    for (int c = 0; c < 16 && k < 4; c++) begin
      rdy = (c % 2 == 0);
      @(negedge clk);
      if (if_rr.cntrlr_rden) pulses++;
      if (!rdy) begin
        chk("bp_wait", {63'h0, wt[2]}, 64'h1);
      end else begin
        chk("bp_grant", {63'h0, wt[2]}, 64'h0);
        chk("bp_addr", {37'h0, if_rr.cntrlr_addr}, 64'h10 + 64'(k));
        k++;
      end
      tick();
      if (rdy && k < 4) begin
        set_addr(2, 27'h10 + 27'(k));
        exp_q.push_back('{4'b0100, ret_data(27'h10 + 27'(k))});
      end
    end
    rden[2] = 1'b0;
    rdy     = 1'b1;
    chk("bp_pulses", 64'(pulses), 64'd4);
    repeat (8) tick();
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Read routing, interleaved agents
    do_read(0, 27'h100);
    do_read(1, 27'h200);
    do_read(0, 27'h104);
    repeat (8) tick();
    chk("route_drain", 64'(exp_q.size()), 64'd0);
    chk("route_ro", {60'h0, ro}, 64'h0);

    // FIFO full
    auto_ret = 1'b0;
    ret_v    = 1'b0;
    for (int i = 0; i < 8; i++) do_read(0, 27'h300 + 27'(i));
    @(negedge clk);
    chk("full_cnt", {60'h0, ro}, 64'h8);
    tick();
    rden[1] = 1'b1;
    set_addr(1, 27'h308);
    exp_q.push_back('{4'b0010, ret_data(27'h308)});
    wren[3] = 1'b1;
    @(negedge clk);
    chk("full_held", {63'h0, wt[1]}, 64'h1);
    chk("full_wr_gnt", {63'h0, wt[3]}, 64'h0);
    chk("full_wr_cmd", {63'h0, if_rr.cntrlr_wren}, 64'h1);
    tick();
    wren[3] = 1'b0;
    @(negedge clk);
    chk("full_held2", {63'h0, wt[1]}, 64'h1);
    chk("full_no_rd", {63'h0, if_rr.cntrlr_rden}, 64'h0);
    tick();
    ret_v = 1'b1;
    ret_d = ret_data(pend[0].a);
    void'(pend.pop_front());
    @(negedge clk);
    chk("full_pop_same", {63'h0, wt[1]}, 64'h1);
    chk("full_cnt2", {60'h0, ro}, 64'h8);
    tick();
    ret_v = 1'b0;
    @(negedge clk);
    chk("full_cnt3", {60'h0, ro}, 64'h7);
    chk("full_unblk", {63'h0, wt[1]}, 64'h0);
    chk("full_addr", {37'h0, if_rr.cntrlr_addr}, 64'h308);
    tick();
    rden[1]  = 1'b0;
    auto_ret = 1'b1;
    for (int n = 0; n < 60 && (ro != 0 || exp_q.size() != 0); n++)
      @(negedge clk);
    chk("full_drain", 64'(exp_q.size()), 64'd0);
    chk("full_ro0", {60'h0, ro}, 64'h0);
    tick();

    // Unexpected return
    sb_on    = 1'b0;
    auto_ret = 1'b0;
    tick();
    ret_v = 1'b1;
    ret_d = 32'h1234_5678;
    tick();
    ret_v = 1'b0;
    @(negedge clk);
    chk("unexp_rv", {60'h0, rv}, 64'h0);
    chk("unexp_err", {63'h0, err}, 64'h1);
    chk("unexp_hold", {32'h0, rdat[31:0]}, {32'h0, ret_data(27'h308)});
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", {63'h0, err}, 64'h1);
    tick();

    // Reset with three reads outstanding
    do_read(1, 27'h400);
    do_read(1, 27'h401);
    do_read(1, 27'h402);
    exp_q.delete();
    @(negedge clk);
    chk("mid_ro3", {60'h0, ro}, 64'h3);
    wren[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ro", {60'h0, ro}, 64'h0);
    chk("mid_wait", {60'h0, wt}, 64'hF);
    chk("mid_wren", {63'h0, if_rr.cntrlr_wren}, 64'h0);
    chk("mid_err", {63'h0, err}, 64'h0);
    chk("mid_rdata", rdat[63:0], 64'h0);
    chk("mid_rv", {60'h0, rv}, 64'h0);
    wren = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ret_v = 1'b1;
    ret_d = ret_data(pend[0].a);
    void'(pend.pop_front());
    tick();
    ret_v = 1'b0;
    @(negedge clk);
    chk("late_err", {63'h0, err}, 64'h1);
    chk("late_rv", {60'h0, rv}, 64'h0);
    chk("late_ro", {60'h0, ro}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
